uart_receiver_controller: RTL and testbench

- Serial-to-parallel UART receive stage. Consumes the line driven by transmitter_controller's ser_out: idle-high line, one start bit (0), 8 data bits MSB first, one stop bit (1).
- Oversamples the line at 16x the selected baud rate and samples each bit at mid-bit.
- Presents the received byte to the board side with a ready/acknowledge handshake, framing-error flag and overrun flag.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_tick_gen.sv | 55 +++++
 rtl/uart_receiver_controller.sv | 175 +++++++++++++++++
 tb/tb_uart_receiver_controller.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and baud arithmetic for the UART receive path.
// Divisors are rounded to the nearest integer clock count per 16x tick.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;

  localparam int unsigned BAUD_RATE [4] = '{
    BAUD_9600,
    BAUD_19200,
    BAUD_57600,
    BAUD_115200
  };

  function automatic int unsigned baud_div(
    input int unsigned clk_freq,
    input int unsigned baud
  );
    int unsigned den;
    den = OVERSAMPLE * baud;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// uart_rx_tick_gen: 16x oversampling enable for the receiver.
// Held at phase zero while clear is high so ticks align to the start edge.
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int          CNT_W    = 16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [1:0] s_latched,
  input  logic       clear,
  output logic       tick16
);

  localparam logic [CNT_W-1:0] DIV0_M1 =
    CNT_W'(baud_div(CLK_FREQ, BAUD_RATE[0]) - 1);
  localparam logic [CNT_W-1:0] DIV1_M1 =
    CNT_W'(baud_div(CLK_FREQ, BAUD_RATE[1]) - 1);
  localparam logic [CNT_W-1:0] DIV2_M1 =
    CNT_W'(baud_div(CLK_FREQ, BAUD_RATE[2]) - 1);
  localparam logic [CNT_W-1:0] DIV3_M1 =
    CNT_W'(baud_div(CLK_FREQ, BAUD_RATE[3]) - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_m1;
  logic             wrap;

  // terminal count for the latched baud rate
  always_comb begin
    div_m1 = DIV0_M1;
    unique case (s_latched)
      2'b00: div_m1 = DIV0_M1;
      2'b01: div_m1 = DIV1_M1;
      2'b10: div_m1 = DIV2_M1;
      2'b11: div_m1 = DIV3_M1;
      default: div_m1 = DIV0_M1;
    endcase
  end

  assign wrap   = (cnt >= div_m1);
  assign tick16 = wrap && !clear;

  // free-running divider, parked at zero while cleared
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver_controller.sv
// uart_receiver_controller: 16x oversampled UART receive stage with a
// ready/ack byte handshake plus framing and overrun error pulses.
module uart_receiver_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned DATA_BITS = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [1:0]           S,
  input  logic                 rx_in,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned BC_W =
    (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS - 1);
  localparam logic [3:0] TICK_MID = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TICK_END = 4'(OVERSAMPLE - 1);

  rx_state_t state;
  rx_state_t state_nxt;

  logic                 sync1;
  logic                 rx_s;
  logic [1:0]           s_latched;
  logic                 tick16;
  logic                 tick_clr;
  logic [3:0]           tick_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shift_q;

  logic start_det;
  logic mid_start;
  logic mid_data;
  logic last_bit;
  logic mid_stop;
  logic stop_ok;
  logic stop_bad;

  // two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  uart_rx_tick_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_tick (
    .clk_in    (clk_in),
    .reset     (reset),
    .s_latched (s_latched),
    .clear     (tick_clr),
    .tick16    (tick16)
  );

  // state register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_det) state_nxt = START;
      end
      START: begin
        if (mid_start) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (last_bit) state_nxt = STOP;
      end
      STOP: begin
        if (stop_ok) state_nxt = IDLE;
        else if (stop_bad) state_nxt = BREAK;
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sample strobes and status outputs
  always_comb begin
    start_det = (state == IDLE) && !rx_s;
    mid_start = (state == START) && tick16 && (tick_cnt == TICK_MID);
    mid_data  = (state == DATA) && tick16 && (tick_cnt == TICK_END);
    last_bit  = mid_data && (bit_cnt == LAST_BIT);
    mid_stop  = (state == STOP) && tick16 && (tick_cnt == TICK_END);
    stop_ok   = mid_stop && rx_s;
    stop_bad  = mid_stop && !rx_s;
    tick_clr  = (state == IDLE);
    busy      = (state != IDLE);
  end

  // baud select is frozen for the whole frame at the start edge
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s_latched <= 2'b00;
    end else if (start_det) begin
      s_latched <= S;
    end
  end

  // tick and bit counters within the frame
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state == IDLE || mid_start) begin
        tick_cnt <= '0;
      end else if (tick16) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (mid_start) begin
        bit_cnt <= '0;
      end else if (mid_data) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // mid-bit shift register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
    end else if (mid_data) begin
      if (MSB_FIRST) begin
        shift_q <= {shift_q[DATA_BITS-2:0], rx_s};
      end else begin
        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
      end
    end
  end

  // board-side byte handshake and error pulses
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      rx_ready    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= stop_ok && rx_ready && !rd_ack;
      if (stop_ok) begin
        data_out <= shift_q;
        rx_ready <= 1'b1;
      end else if (rd_ack) begin
        rx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver_controller.sv
// tb_uart_receiver_controller: scenario tasks plus a randomized run
// against a byte-level model of the receive handshake.
module tb_uart_receiver_controller;

  localparam int CLK_FREQ = 8_000_000;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic [1:0] S      = 2'b11;
  logic       rx_in  = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] data_out;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rdy_rises = 0;
  int rdy_rise_cyc = 0;
  int busy_rise_cyc = 0;
  int busy_fall_cyc = 0;
  int frame_start = 0;
  logic rdy_d = 1'b0;
  logic busy_d = 1'b0;
  logic [7:0] exp_data = 8'h00;

  uart_receiver_controller #(
    .CLK_FREQ (CLK_FREQ)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .S           (S),
    .rx_in       (rx_in),
    .rd_ack      (rd_ack),
    .data_out    (data_out),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    cyc = cyc + 1;
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun_err) ov_cnt = ov_cnt + 1;
    if (rx_ready && !rdy_d) begin
      rdy_rises = rdy_rises + 1;
      rdy_rise_cyc = cyc;
    end
    if (busy && !busy_d) busy_rise_cyc = cyc;
    if (!busy && busy_d) busy_fall_cyc = cyc;
    rdy_d = rx_ready;
    busy_d = busy;
  end

  function automatic int div_of(input logic [1:0] s);
    int baud;
    case (s)
      2'b00: baud = 9600;
      2'b01: baud = 19200;
      2'b10: baud = 57600;
      default: baud = 115200;
    endcase
    return (CLK_FREQ + 8 * baud) / (16 * baud);
  endfunction

  function automatic int bitclk_of(input logic [1:0] s);
    return 16 * div_of(s);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_in);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int bitclk);
    frame_start = cyc;
    rx_in = 1'b0;
    tick(bitclk);
    for (int i = 7; i >= 0; i--) begin
      rx_in = b[i];
      tick(bitclk);
    end
    rx_in = stop;
    tick(bitclk);
  endtask

  task automatic do_ack();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data got %h want 00", data_out);
    end
    n_checks++;
    if ({rx_ready, frame_err, overrun_err, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000",
               {rx_ready, frame_err, overrun_err, busy});
    end
  endtask

  task automatic test_basic();
    int bc, dv, lat, r0, f0;
    S = 2'b11;
    bc = bitclk_of(2'b11);
    dv = div_of(2'b11);
    r0 = rdy_rises;
    f0 = fe_cnt;
    fork
      send_frame(8'hA5, 1'b1, bc);
      begin
        tick(3 * bc);
        S = 2'b00;
      end
    join
    tick(bc);
    exp_data = 8'hA5;
    n_checks++;
    if (data_out !== exp_data) begin
      n_fail++;
      $display("FAIL basic_data got %h want %h", data_out, exp_data);
    end
    n_checks++;
    if (rx_ready !== 1'b1 || rdy_rises !== r0 + 1) begin
      n_fail++;
      $display("FAIL basic_ready got %b/%0d want 1/%0d",
               rx_ready, rdy_rises - r0, 1);
    end
    lat = rdy_rise_cyc - frame_start;
    n_checks++;
    if (lat < 152 * dv - dv - 4 || lat > 152 * dv + dv + 4) begin
      n_fail++;
      $display("FAIL basic_latency got %0d want %0d +/- %0d",
               lat, 152 * dv, dv + 4);
    end
    n_checks++;
    if (fe_cnt !== f0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_err_busy got fe=%0d busy=%b want fe=0 busy=0",
               fe_cnt - f0, busy);
    end
    do_ack();
    n_checks++;
    if (rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ack got %b want 0", rx_ready);
    end
    S = 2'b11;
  endtask

  task automatic test_glitch();
    int bc, dv, dur, r0, f0;
    S = 2'b00;
    bc = bitclk_of(2'b00);
    dv = div_of(2'b00);
    r0 = rdy_rises;
    f0 = fe_cnt;
    rx_in = 1'b0;
    tick(bc * 3 / 10);
    rx_in = 1'b1;
    tick(bc);
    dur = busy_fall_cyc - busy_rise_cyc;
    n_checks++;
    if (dur < 8 * dv - 2 || dur > 8 * dv + 2) begin
      n_fail++;
      $display("FAIL glitch_busy_len got %0d want %0d", dur, 8 * dv);
    end
    n_checks++;
    if (rdy_rises !== r0 || fe_cnt !== f0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_quiet got rdy=%0d fe=%0d busy=%b want 0 0 0",
               rdy_rises - r0, fe_cnt - f0, busy);
    end
  endtask

  task automatic test_frame_error();
    int bc, f0, o0;
    S = 2'b10;
    bc = bitclk_of(2'b10);
    f0 = fe_cnt;
    o0 = ov_cnt;
    send_frame(8'h3C, 1'b0, bc);
    tick(2 * bc);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ferr_break_busy got %b want 1", busy);
    end
    rx_in = 1'b1;
    tick(bc);
    n_checks++;
    if (fe_cnt !== f0 + 1) begin
      n_fail++;
      $display("FAIL ferr_pulses got %0d want 1", fe_cnt - f0);
    end
    n_checks++;
    if (rx_ready !== 1'b0 || data_out !== exp_data || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_hold got rdy=%b data=%h busy=%b want 0 %h 0",
               rx_ready, data_out, busy, exp_data);
    end
    send_frame(8'h81, 1'b1, bc);
    tick(bc);
    exp_data = 8'h81;
    n_checks++;
    if (data_out !== exp_data || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ferr_next got %h/%b want %h/1",
               data_out, rx_ready, exp_data);
    end
    n_checks++;
    if (fe_cnt !== f0 + 1 || ov_cnt !== o0) begin
      n_fail++;
      $display("FAIL ferr_next_flags got fe=%0d ov=%0d want 1 0",
               fe_cnt - f0, ov_cnt - o0);
    end
    do_ack();
  endtask

  task automatic test_overrun();
    int bc, o0, lat, c0;
    S = 2'b01;
    bc = bitclk_of(2'b01);
    o0 = ov_cnt;
    send_frame(8'h11, 1'b1, bc);
    send_frame(8'h22, 1'b1, bc);
    exp_data = 8'h22;
    n_checks++;
    if (ov_cnt !== o0 + 1) begin
      n_fail++;
      $display("FAIL overrun_count got %0d want 1", ov_cnt - o0);
    end
    n_checks++;
    if (data_out !== exp_data || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_data got %h/%b want %h/1",
               data_out, rx_ready, exp_data);
    end
    do_ack();
    o0 = ov_cnt;
    send_frame(8'h11, 1'b1, bc);
    lat = rdy_rise_cyc - frame_start;
    c0 = cyc;
    fork
      send_frame(8'h22, 1'b1, bc);
      begin
        tick(lat - 1);
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
      end
    join
    n_checks++;
    if (ov_cnt !== o0) begin
      n_fail++;
      $display("FAIL ack_coincident_ov got %0d want 0 (ack at %0d)",
               ov_cnt - o0, c0 + lat - 1);
    end
    n_checks++;
    if (data_out !== exp_data || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_coincident_data got %h/%b want %h/1",
               data_out, rx_ready, exp_data);
    end
    do_ack();
  endtask

  task automatic test_reset_midframe();
    int bc, f0;
    logic [7:0] b;
    S = 2'b11;
    bc = bitclk_of(2'b11);
    b = 8'hF0;
    f0 = fe_cnt;
    rx_in = 1'b0;
    tick(bc);
    for (int i = 7; i >= 3; i--) begin
      rx_in = b[i];
      tick(i == 3 ? bc / 2 : bc);
    end
    reset = 1'b1;
    rx_in = 1'b1;
    tick(3);
    exp_data = 8'h00;
    test_reset();
    reset = 1'b0;
    tick(bc);
    n_checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release got busy=%b rdy=%b want 0 0",
               busy, rx_ready);
    end
    send_frame(8'h5A, 1'b1, bc);
    tick(bc);
    exp_data = 8'h5A;
    n_checks++;
    if (data_out !== exp_data || rx_ready !== 1'b1 || fe_cnt !== f0) begin
      n_fail++;
      $display("FAIL rst_next got %h/%b fe=%0d want %h/1 fe=0",
               data_out, rx_ready, fe_cnt - f0, exp_data);
    end
    do_ack();
  endtask

  task automatic test_loopback();
    logic [7:0] q[$];
    logic [7:0] want;
    int bc, f0, o0;
    S = 2'b11;
    bc = bitclk_of(2'b11);
    f0 = fe_cnt;
    o0 = ov_cnt;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'h96);
    foreach (q[i]) send_frame_check(q[i], bc);
    while (q.size() > 0) begin
      want = q.pop_front();
      exp_data = want;
    end
    n_checks++;
    if (fe_cnt !== f0 || ov_cnt !== o0) begin
      n_fail++;
      $display("FAIL loopback_flags got fe=%0d ov=%0d want 0 0",
               fe_cnt - f0, ov_cnt - o0);
    end
  endtask

  task automatic send_frame_check(input logic [7:0] b, input int bc);
    send_frame(b, 1'b1, bc);
    tick(bc / 4);
    n_checks++;
    if (data_out !== b || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL loopback_byte got %h/%b want %h/1",
               data_out, rx_ready, b);
    end
    do_ack();
  endtask

  task automatic test_random();
    logic [1:0] s;
    logic [7:0] b;
    logic       good;
    logic       m_ready;
    logic [7:0] m_data;
    int         m_fe, m_ov, f0, o0, bc;
    m_ready = 1'b0;
    m_data = exp_data;
    m_fe = 0;
    m_ov = 0;
    f0 = fe_cnt;
    o0 = ov_cnt;
    for (int n = 0; n < 10; n++) begin
      s = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
      S = s;
      bc = bitclk_of(s);
      b = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      send_frame(b, good, bc);
      if (good) begin
        if (m_ready) m_ov++;
        m_ready = 1'b1;
        m_data = b;
        tick($urandom_range(0, bc / 2));
      end else begin
        m_fe++;
        tick($urandom_range(1, bc));
        rx_in = 1'b1;
        tick(bc / 2 + 4);
      end
      n_checks++;
      if (data_out !== m_data || rx_ready !== m_ready) begin
        n_fail++;
        $display("FAIL random_%0d got %h/%b want %h/%b",
                 n, data_out, rx_ready, m_data, m_ready);
      end
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        m_ready = 1'b0;
      end
    end
    n_checks++;
    if (fe_cnt - f0 !== m_fe || ov_cnt - o0 !== m_ov) begin
      n_fail++;
      $display("FAIL random_flags got fe=%0d ov=%0d want fe=%0d ov=%0d",
               fe_cnt - f0, ov_cnt - o0, m_fe, m_ov);
    end
    exp_data = m_data;
    do_ack();
  endtask

  initial begin
    reset = 1'b1;
    tick(5);
    test_reset();
    reset = 1'b0;
    tick(5);
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_midframe();
    test_loopback();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
